// File: rtl/tick_rate_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tick_rate_pkg
//  Purpose  : Shared types and helpers for the slow-clock rate controller:
//             FSM state encoding, rate index type and the rate -> half-period
//             lookup.
//  Ports    : (package, none)
//  Revision : 1.0  initial release
// ============================================================================
package tick_rate_pkg;

    localparam int unsigned c_RATE_W = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    typedef logic [c_RATE_W-1:0] rate_t;

    // Maps a rate index onto its half-period length in fastCLK cycles.
    function automatic int unsigned halfOf(
        input rate_t       rate,
        input int unsigned h0,
        input int unsigned h1,
        input int unsigned h2,
        input int unsigned h3
    );
        int unsigned v;
        v = h0;
        case (rate)
            2'd0:    v = h0;
            2'd1:    v = h1;
            2'd2:    v = h2;
            default: v = h3;
        endcase
        return v;
    endfunction

endpackage : tick_rate_pkg
`default_nettype wire

// File: rtl/tick_rate_controller_counter.sv
`default_nettype none
// ============================================================================
//  Module   : half_period_counter
//  Purpose  : Half-period counter with terminal-count detect. Counts up from
//             0 and returns to 0 at terminal count; the >= compare means a
//             counter already beyond the limit (limit lowered mid-count)
//             still recovers on the next cycle instead of wrapping.
//  Ports    : fastCLK  in   system clock
//             resetN   in   asynchronous active-low reset
//             clear    in   force counter to 0 on the next edge
//             limit    in   terminal value (half-period minus one)
//             tc       out  counter has reached the terminal value
//  Revision : 1.0  initial release
// ============================================================================
module half_period_counter #(
    parameter int unsigned CNT_W = 24
) (
    input  logic             fastCLK,
    input  logic             resetN,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    logic [CNT_W-1:0] r_count;

    assign tc = (r_count >= limit);

    always_ff @(posedge fastCLK or negedge resetN) begin
        if (!resetN) begin
            r_count <= '0;
        end else if (clear || tc) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule : half_period_counter
`default_nettype wire

// File: rtl/tick_rate_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tick_rate_controller
//  Purpose  : Divides fastCLK into a 50% duty slowCLK at one of four rates.
//             Start/stop is sequenced so slowCLK never produces a runt high
//             pulse, and rate changes take effect only on the falling edge of
//             slowCLK (full-period boundary) or immediately while idle.
//  Ports    : fastCLK         in   system clock, rising edge
//             resetN          in   asynchronous active-low reset
//             enable          in   1 = run, 0 = stop after the high phase
//             rate_sel[1:0]   in   requested rate index
//             rate_load       in   strobe capturing rate_sel
//             slowCLK         out  divided clock (registered)
//             tick            out  pulse in the cycle slowCLK toggles
//             cur_rate[1:0]   out  rate index in effect
//             change_pending  out  a loaded rate awaits a boundary
//             change_ack      out  pulse in the cycle a rate is applied
//  Revision : 1.0  initial release
// ============================================================================
module tick_rate_controller
    import tick_rate_pkg::*;
#(
    parameter int unsigned CNT_W        = 24,
    parameter int unsigned HALF0        = 100000,
    parameter int unsigned HALF1        = 1600000,
    parameter int unsigned HALF2        = 50000,
    parameter int unsigned HALF3        = 25000,
    parameter logic [1:0]  DEFAULT_RATE = 2'd0
) (
    input  logic       fastCLK,
    input  logic       resetN,
    input  logic       enable,
    input  logic [1:0] rate_sel,
    input  logic       rate_load,
    output logic       slowCLK,
    output logic       tick,
    output logic [1:0] cur_rate,
    output logic       change_pending,
    output logic       change_ack
);

    state_t           r_state;
    state_t           w_stateNext;
    logic             r_slowClk;
    logic             r_tick;
    rate_t            r_curRate;
    rate_t            r_pendingRate;
    logic             r_changePending;
    logic             r_changeAck;

    logic [CNT_W-1:0] w_limit;
    logic             w_tc;
    logic             w_clear;
    logic             w_active;
    logic             w_toggle;
    logic             w_boundary;
    logic             w_applyNow;
    rate_t            w_applyRate;

    // Terminal value is one less than the half-period length.
    assign w_limit = CNT_W'(halfOf(r_curRate, HALF0, HALF1, HALF2, HALF3) - 32'd1);

    half_period_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .fastCLK (fastCLK),
        .resetN  (resetN),
        .clear   (w_clear),
        .limit   (w_limit),
        .tc      (w_tc)
    );

    // ------------------------------------------------------------------
    // Next-state logic. w_active marks cycles in which the counter is
    // allowed to toggle slowCLK; w_clear holds the counter at 0.
    // A stop request while slowCLK is high keeps counting so the high
    // phase completes at full length before returning to IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext = r_state;
        w_clear     = 1'b0;
        w_active    = 1'b0;
        case (r_state)
            IDLE: begin
                w_clear = 1'b1;
                if (enable) begin
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                if (enable) begin
                    w_active = 1'b1;
                end else if (!r_slowClk) begin
                    // Low phase: stopping here cannot shorten a high pulse.
                    w_clear     = 1'b1;
                    w_stateNext = IDLE;
                end else begin
                    w_active    = 1'b1;
                    w_stateNext = w_tc ? IDLE : STOPPING;
                end
            end
            STOPPING: begin
                w_active = 1'b1;
                if (enable) begin
                    w_stateNext = RUN;
                end else if (w_tc) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_clear     = 1'b1;
                w_stateNext = IDLE;
            end
        endcase
    end

    assign w_toggle   = w_active & w_tc;
    assign w_boundary = w_toggle & r_slowClk;

    // A rate is applied on a falling-edge boundary (if one is pending or
    // arriving this cycle) or on the cycle after a load while idle. A load
    // coinciding with the apply wins over the older pending value.
    assign w_applyNow  = (w_boundary & (rate_load | r_changePending))
                       | ((r_state == IDLE) & r_changePending);
    assign w_applyRate = rate_load ? rate_sel : r_pendingRate;

    always_ff @(posedge fastCLK or negedge resetN) begin
        if (!resetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge fastCLK or negedge resetN) begin
        if (!resetN) begin
            r_slowClk       <= 1'b0;
            r_tick          <= 1'b0;
            r_curRate       <= DEFAULT_RATE;
            r_pendingRate   <= '0;
            r_changePending <= 1'b0;
            r_changeAck     <= 1'b0;
        end else begin
            r_tick      <= w_toggle;
            r_changeAck <= w_applyNow;
            if (w_toggle) begin
                r_slowClk <= ~r_slowClk;
            end
            if (w_applyNow) begin
                r_curRate       <= w_applyRate;
                r_changePending <= 1'b0;
            end else if (rate_load) begin
                r_pendingRate   <= rate_sel;
                r_changePending <= 1'b1;
            end
        end
    end

    assign slowCLK        = r_slowClk;
    assign tick           = r_tick;
    assign cur_rate       = r_curRate;
    assign change_pending = r_changePending;
    assign change_ack     = r_changeAck;

endmodule : tick_rate_controller
`default_nettype wire

// File: tb/tb_tick_rate_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tick_rate_controller
//  Purpose  : Scoreboard bench for tick_rate_controller with short
//             half-periods (4/8/2/3). Expected tick/ack events are queued by
//             the stimulus process and checked by an independent monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tick_rate_controller;

    logic       fastCLK   = 1'b0;
    logic       resetN    = 1'b0;
    logic       enable    = 1'b0;
    logic [1:0] rate_sel  = 2'd0;
    logic       rate_load = 1'b0;
    logic       slowCLK;
    logic       tick;
    logic [1:0] cur_rate;
    logic       change_pending;
    logic       change_ack;

    int testsRun    = 0;
    int testsFailed = 0;
    int edgeCnt     = 0;

    typedef struct {
        int         edgeNo;
        logic       tk;
        logic       ak;
        logic       slow;
        logic [1:0] rate;
    } ev_t;

    ev_t expQ[$];
    ev_t monEv;

    tick_rate_controller #(
        .CNT_W        (24),
        .HALF0        (4),
        .HALF1        (8),
        .HALF2        (2),
        .HALF3        (3),
        .DEFAULT_RATE (2'd0)
    ) dut (
        .fastCLK        (fastCLK),
        .resetN         (resetN),
        .enable         (enable),
        .rate_sel       (rate_sel),
        .rate_load      (rate_load),
        .slowCLK        (slowCLK),
        .tick           (tick),
        .cur_rate       (cur_rate),
        .change_pending (change_pending),
        .change_ack     (change_ack)
    );

    always #5 fastCLK = ~fastCLK;

    always @(posedge fastCLK) edgeCnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edgeCnt);
        end
    endtask

    task automatic pushExp(input int n, input logic tk, input logic ak,
                           input logic sl, input logic [1:0] r);
        expQ.push_back('{n, tk, ak, sl, r});
    endtask

    // Moves to the falling clock edge that follows rising edge k.
    task automatic afterEdge(input int k);
        while (edgeCnt < k) @(negedge fastCLK);
        if (edgeCnt != k) begin
            testsRun++;
            testsFailed++;
            $display("FAIL sequencing: at edge %0d wanted %0d", edgeCnt, k);
        end
    endtask

    // Monitor: every tick or ack the DUT presents must match the next
    // queued expectation in edge number and output values.
    always @(negedge fastCLK) begin
        if (resetN && (tick || change_ack)) begin
            testsRun++;
            if (expQ.size() == 0) begin
                testsFailed++;
                $display("FAIL unexpected_event: edge %0d tick=%0b ack=%0b slow=%0b rate=%0d, none expected",
                         edgeCnt, tick, change_ack, slowCLK, cur_rate);
            end else begin
                monEv = expQ.pop_front();
                if (monEv.edgeNo != edgeCnt || monEv.tk !== tick || monEv.ak !== change_ack ||
                    monEv.slow !== slowCLK || monEv.rate !== cur_rate) begin
                    testsFailed++;
                    $display("FAIL event: got edge %0d tick=%0b ack=%0b slow=%0b rate=%0d, expected edge %0d tick=%0b ack=%0b slow=%0b rate=%0d",
                             edgeCnt, tick, change_ack, slowCLK, cur_rate,
                             monEv.edgeNo, monEv.tk, monEv.ak, monEv.slow, monEv.rate);
                end
            end
        end
    end

    initial begin
        int b, c, d, e, f;

        // Reset state
        repeat (3) @(negedge fastCLK);
        check("rst_slowCLK", 32'(slowCLK), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_cur_rate", 32'(cur_rate), 32'd0);
        check("rst_pending", 32'(change_pending), 32'd0);
        check("rst_ack", 32'(change_ack), 32'd0);
        resetN = 1'b1;
        @(negedge fastCLK);
        check("idle_slowCLK", 32'(slowCLK), 32'd0);

        // Start at rate 0, load rate 1 during the first high phase
        b = edgeCnt + 1;
        enable = 1'b1;
        pushExp(b + 4,  1'b1, 1'b0, 1'b1, 2'd0);
        pushExp(b + 8,  1'b1, 1'b1, 1'b0, 2'd1);
        pushExp(b + 16, 1'b1, 1'b0, 1'b1, 2'd1);
        afterEdge(b + 4);
        rate_sel  = 2'd1;
        rate_load = 1'b1;
        afterEdge(b + 5);
        rate_load = 1'b0;
        check("pending_c5", 32'(change_pending), 32'd1);
        check("rate_held_c5", 32'(cur_rate), 32'd0);
        afterEdge(b + 7);
        check("pending_c7", 32'(change_pending), 32'd1);
        afterEdge(b + 8);
        check("pending_clr_c8", 32'(change_pending), 32'd0);
        check("rate_c8", 32'(cur_rate), 32'd1);

        // Stop two cycles after a rise: high phase runs to full length
        afterEdge(b + 17);
        enable = 1'b0;
        pushExp(b + 24, 1'b1, 1'b0, 1'b0, 2'd1);
        afterEdge(b + 23);
        check("stop_still_high", 32'(slowCLK), 32'd1);
        afterEdge(b + 24);
        check("stop_fell", 32'(slowCLK), 32'd0);

        // Stop in low phase, then restart: counter must restart from 0
        afterEdge(b + 30);
        c = b + 31;
        enable = 1'b1;
        afterEdge(c + 1);
        enable = 1'b0;
        afterEdge(c + 2);
        check("lowstop_slowCLK", 32'(slowCLK), 32'd0);
        afterEdge(c + 5);
        d = c + 6;
        enable = 1'b1;
        pushExp(d + 8, 1'b1, 1'b0, 1'b1, 2'd1);
        afterEdge(d + 8);
        enable = 1'b0;
        pushExp(d + 16, 1'b1, 1'b0, 1'b0, 2'd1);

        // Idle load of rate 3: acknowledged the following cycle
        afterEdge(d + 20);
        e = d + 21;
        rate_sel  = 2'd3;
        rate_load = 1'b1;
        pushExp(e + 1, 1'b0, 1'b1, 1'b0, 2'd3);
        afterEdge(e);
        rate_load = 1'b0;
        check("idle_pending", 32'(change_pending), 32'd1);
        afterEdge(e + 1);
        check("idle_rate3", 32'(cur_rate), 32'd3);
        check("idle_pending_clr", 32'(change_pending), 32'd0);

        // Rate 3 run; double load (last wins, one ack); load at boundary
        afterEdge(e + 2);
        f = e + 3;
        enable = 1'b1;
        pushExp(f + 3,  1'b1, 1'b0, 1'b1, 2'd3);
        pushExp(f + 6,  1'b1, 1'b1, 1'b0, 2'd0);
        pushExp(f + 10, 1'b1, 1'b0, 1'b1, 2'd0);
        pushExp(f + 14, 1'b1, 1'b1, 1'b0, 2'd2);
        pushExp(f + 16, 1'b1, 1'b0, 1'b1, 2'd2);
        afterEdge(f + 3);
        rate_sel  = 2'd2;
        rate_load = 1'b1;
        afterEdge(f + 4);
        rate_sel  = 2'd0;
        afterEdge(f + 5);
        rate_load = 1'b0;
        check("dbl_pending", 32'(change_pending), 32'd1);
        afterEdge(f + 13);
        rate_sel  = 2'd2;
        rate_load = 1'b1;
        afterEdge(f + 14);
        rate_load = 1'b0;
        check("direct_no_pending", 32'(change_pending), 32'd0);

        // Asynchronous reset in the high phase with a rate pending
        afterEdge(f + 16);
        rate_sel  = 2'd1;
        rate_load = 1'b1;
        afterEdge(f + 17);
        rate_load = 1'b0;
        check("pre_rst_pending", 32'(change_pending), 32'd1);
        check("pre_rst_high", 32'(slowCLK), 32'd1);
        check("pre_rst_rate", 32'(cur_rate), 32'd2);
        #2;
        resetN = 1'b0;
        enable = 1'b0;
        #1;
        check("async_slowCLK", 32'(slowCLK), 32'd0);
        check("async_pending", 32'(change_pending), 32'd0);
        check("async_rate", 32'(cur_rate), 32'd0);
        check("async_tick", 32'(tick), 32'd0);
        repeat (2) @(negedge fastCLK);
        resetN = 1'b1;
        repeat (4) @(negedge fastCLK);
        check("post_rst_slowCLK", 32'(slowCLK), 32'd0);
        check("leftover_events", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule : tb_tick_rate_controller
`default_nettype wire
